tick_divider: RTL and testbench

TICK_DIVIDER -- requirements
Module: tick_divider

---
 rtl/tick_divider.sv | 81 ++++++++
 tb/tb_tick_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tick_divider.sv
// Purpose: NCH independent programmable tick dividers, each emitting a one-cycle enable pulse and a 50% square wave.
// Latency: tick/sq are registered, asserted on the edge where the counter reaches div-1; div_q is the live divisor register.
// Backpressure: none; run=0 freezes every counter and square wave, and suppresses ticks from the next edge on.
module tick_divider #(
    parameter int                     NCH      = 4,
    parameter int                     DIV_W    = 27,
    parameter logic [NCH*DIV_W-1:0]   DIV_INIT = {27'd100000000, 27'd25000000, 27'd50000000, 27'd100000}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   sync,
    input  logic                   wr_en,
    input  logic [2:0]             wr_sel,
    input  logic [DIV_W-1:0]       wr_data,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq,
    output logic [NCH*DIV_W-1:0]   div_q
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch

        logic [DIV_W-1:0] div_r;
        logic [DIV_W-1:0] cnt_r;
        logic             tick_r;
        logic             sq_r;
        logic             wr_hit;
        logic             at_top;

        // A select of NCH or above never matches any channel index, so such writes fall through harmlessly.
        assign wr_hit = wr_en && (wr_sel == 3'(i));

        // Terminal count; only meaningful when div_r is non-zero (div_r == 0 is handled before this is used).
        assign at_top = (cnt_r == div_r - DIV_W'(1));

        // Divisor register: any write to this channel lands, even when sync overrides the counter side.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_r <= DIV_INIT[i*DIV_W +: DIV_W];
            end else if (wr_hit) begin
                div_r <= wr_data;
            end
        end

        // Counter, tick and square wave with sync > write > count priority.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r  <= '0;
                tick_r <= 1'b0;
                sq_r   <= 1'b0;
            end else if (sync) begin
                cnt_r  <= '0;
                tick_r <= 1'b0;
                sq_r   <= 1'b0;
            end else if (wr_hit) begin
                // Restart the period so the next tick lands wr_data run-edges later; phase of sq is kept.
                cnt_r  <= '0;
                tick_r <= 1'b0;
            end else if (!run) begin
                tick_r <= 1'b0;
            end else if (div_r == '0) begin
                // Disabled channel: parked at zero, never ticks, square wave frozen.
                cnt_r  <= '0;
                tick_r <= 1'b0;
            end else if (at_top) begin
                cnt_r  <= '0;
                tick_r <= 1'b1;
                sq_r   <= ~sq_r;
            end else begin
                cnt_r  <= cnt_r + DIV_W'(1);
                tick_r <= 1'b0;
            end
        end

        assign tick[i]                    = tick_r;
        assign sq[i]                      = sq_r;
        assign div_q[i*DIV_W +: DIV_W]    = div_r;

    end

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider with NCH=4, DIV_W=8, reset divisors 1,2,3,5.
// Expected tick/sq come from closed-form period formulas per channel (origin edge, divisor, starting sq).
module tb_tick_divider;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam logic [31:0] INIT = 32'h05030201;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic         run     = 1'b0;
    logic         sync    = 1'b0;
    logic         wr_en   = 1'b0;
    logic [2:0]   wr_sel  = 3'd0;
    logic [7:0]   wr_data = 8'd0;
    logic [3:0]   tick;
    logic [3:0]   sq;
    logic [31:0]  div_q;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   keff;
    int   org [4];
    int   dv  [4];
    logic s0  [4];

    tick_divider #(
        .NCH      (NCH),
        .DIV_W    (DIV_W),
        .DIV_INIT (INIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .tick    (tick),
        .sq      (sq),
        .div_q   (div_q)
    );

    always #5 clk = ~clk;

    function automatic logic e_tick(input int k, input int o, input int d);
        if (d == 0 || k <= o) return 1'b0;
        return ((k - o) % d) == 0;
    endfunction

    function automatic logic e_sq(input int k, input int o, input int d, input logic s);
        if (d == 0 || k < o) return s;
        return s ^ ((((k - o) / d) % 2) == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        keff = 0;
        dv   = '{1, 2, 3, 5};
        for (int i = 0; i < NCH; i++) begin
            org[i] = 0;
            s0[i]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag, input bit paused);
        logic [3:0]  et;
        logic [3:0]  es;
        logic [31:0] ed;
        et = '0;
        es = '0;
        ed = '0;
        for (int i = 0; i < NCH; i++) begin
            et[i]         = paused ? 1'b0 : e_tick(keff, org[i], dv[i]);
            es[i]         = e_sq(keff, org[i], dv[i], s0[i]);
            ed[i*8 +: 8]  = 8'(dv[i]);
        end
        chk($sformatf("%s_tick@%0d", tag, keff), 32'(tick), 32'(et));
        chk($sformatf("%s_sq@%0d", tag, keff), 32'(sq), 32'(es));
        chk($sformatf("%s_divq@%0d", tag, keff), div_q, ed);
    endtask

    // One rising edge, then settle to the falling edge for sampling and driving.
    task automatic one_edge(input bit adv);
        @(posedge clk);
        @(negedge clk);
        if (adv) keff++;
    endtask

    task automatic run_edges(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            one_edge(1'b1);
            check_all(tag, 1'b0);
        end
    endtask

    initial begin
        logic p;
        reset_model();

        // Reset state
        #1 rst_n = 1'b0;
        run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_divq", div_q, INIT);

        // Release with run=1: ch3 ticks at 5,10,15; sq3 rises at 5, falls at 10
        rst_n = 1'b1;
        run_edges(17, "count");

        // Pause 3 cycles with cnt3 = 2
        run = 1'b0;
        for (int j = 0; j < 3; j++) begin
            one_edge(1'b0);
            check_all("pause", 1'b1);
        end
        run = 1'b1;
        run_edges(5, "resume");

        // Write ch2=4 while cnt2 = 1 (keff 22 -> write edge 23)
        p       = e_sq(keff, org[2], dv[2], s0[2]);
        wr_en   = 1'b1;
        wr_sel  = 3'd2;
        wr_data = 8'd4;
        one_edge(1'b1);
        org[2] = keff;
        dv[2]  = 4;
        s0[2]  = p;
        check_all("wr_ch2", 1'b0);
        wr_en = 1'b0;
        run_edges(11, "after_wr2");

        // Disable ch1 (sq1 is 1 here and must hold)
        p       = e_sq(keff, org[1], dv[1], s0[1]);
        wr_en   = 1'b1;
        wr_sel  = 3'd1;
        wr_data = 8'd0;
        one_edge(1'b1);
        org[1] = keff;
        dv[1]  = 0;
        s0[1]  = p;
        check_all("wr_ch1_zero", 1'b0);

        // Out-of-range select: no state change
        wr_sel  = 3'd7;
        wr_data = 8'd9;
        one_edge(1'b1);
        check_all("wr_sel7", 1'b0);
        wr_en = 1'b0;
        run_edges(3, "after_sel7");

        // Sync on the edge ch3 would tick (keff 40), with a write of ch3=2
        sync    = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 3'd3;
        wr_data = 8'd2;
        one_edge(1'b1);
        for (int i = 0; i < NCH; i++) begin
            org[i] = keff;
            s0[i]  = 1'b0;
        end
        dv[3] = 2;
        check_all("sync_wr3", 1'b0);
        sync  = 1'b0;
        wr_en = 1'b0;
        run_edges(5, "after_sync");

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_sq", 32'(sq), 32'h0);
        chk("async_rst_divq", div_q, INIT);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run_edges(6, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
